fc_layer_engine: RTL

Parametrised fully-connected layer compute core, the next generation of fc_top_ip. Takes runtime layer dimensions and reads inputs, weights and biases from external synchronous memories. Runs a sequential MAC per output neuron, then adds bias, shifts, saturates and streams results with backpressure. Sits under the FC top wrapper; the top owns memories and the start/done interface to the host.

---
 rtl/fc_pkg.sv | 38 +++
 rtl/fc_mac_acc.sv | 44 ++++
 rtl/fc_layer_engine.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - fc_layer_engine shared states, default widths and shift/saturate helper
package fc_pkg;

  localparam int FC_DATA_W      = 8;
  localparam int FC_OUT_W       = 16;
  localparam int FC_MAX_IN_DIM  = 256;
  localparam int FC_MAX_OUT_DIM = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_BIAS = 3'd1,
    MAC       = 3'd2,
    DRAIN     = 3'd3,
    OUT       = 3'd4,
    FIN       = 3'd5
  } fc_state_e;

  function automatic int fc_acc_w(input int data_w, input int max_in_dim);
    return 2 * data_w + $clog2(max_in_dim) + 1;
  endfunction

  // Arithmetic shift then clamp to the signed range of out_w bits.
  function automatic logic signed [63:0] fc_sat_shift(input logic signed [63:0] acc,
                                                      input int shift, input int out_w);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    v  = acc >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    return r;
  endfunction

endpackage

// File: rtl/fc_mac_acc.sv
// rtl/fc_mac_acc.sv - bias-loaded signed MAC accumulator with shift/saturate; FC_RELU_EN clamps negatives to 0
module fc_mac_acc
  import fc_pkg::*;
#(
  parameter int DATA_W = FC_DATA_W,
  parameter int OUT_W  = FC_OUT_W,
  parameter int ACC_W  = fc_acc_w(FC_DATA_W, FC_MAX_IN_DIM),
  parameter int SHIFT  = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     bias_vld_i,
  input  logic                     prod_vld_i,
  input  logic signed [DATA_W-1:0] b_rdata_i,
  input  logic signed [DATA_W-1:0] x_rdata_i,
  input  logic signed [DATA_W-1:0] w_rdata_i,
  output logic signed [OUT_W-1:0]  res_o
);

  logic signed [ACC_W-1:0]    r_acc;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [OUT_W-1:0]    w_sat;

  assign w_prod = x_rdata_i * w_rdata_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_acc <= '0;
    end else if (bias_vld_i) begin
      r_acc <= ACC_W'(b_rdata_i);
    end else if (prod_vld_i) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  assign w_sat = OUT_W'(fc_sat_shift(64'(r_acc), SHIFT, OUT_W));

`ifdef FC_RELU_EN
  assign res_o = w_sat[OUT_W-1] ? '0 : w_sat;
`else
  assign res_o = w_sat;
`endif

endmodule

// File: rtl/fc_layer_engine.sv
// rtl/fc_layer_engine.sv - FC layer core: FSM, memory address generation, result handshake; FC_RELU_EN enables ReLU
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int DATA_W      = FC_DATA_W,
  parameter int OUT_W       = FC_OUT_W,
  parameter int MAX_IN_DIM  = FC_MAX_IN_DIM,
  parameter int MAX_OUT_DIM = FC_MAX_OUT_DIM,
  parameter int SHIFT       = 0,
  parameter int ACC_W       = fc_acc_w(DATA_W, MAX_IN_DIM),
  parameter int IN_AW       = $clog2(MAX_IN_DIM),
  parameter int OUT_AW      = $clog2(MAX_OUT_DIM),
  parameter int W_AW        = IN_AW + OUT_AW
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [IN_AW:0]    in_dim_i,
  input  logic [OUT_AW:0]   out_dim_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [IN_AW-1:0]  x_addr_o,
  input  logic [DATA_W-1:0] x_rdata_i,
  output logic [W_AW-1:0]   w_addr_o,
  input  logic [DATA_W-1:0] w_rdata_i,
  output logic [OUT_AW-1:0] b_addr_o,
  input  logic [DATA_W-1:0] b_rdata_i,
  output logic              mem_en_o,
  output logic [31:0]       out_wdata_o,
  output logic              out_en_o,
  input  logic              out_ready_i
);

  localparam logic [IN_AW:0]  IN_MAX  = (IN_AW+1)'(MAX_IN_DIM);
  localparam logic [OUT_AW:0] OUT_MAX = (OUT_AW+1)'(MAX_OUT_DIM);

  fc_state_e         r_state;
  logic [IN_AW:0]    r_in_dim;
  logic [OUT_AW:0]   r_out_dim;
  logic [IN_AW-1:0]  r_k;
  logic [OUT_AW-1:0] r_n;
  logic [W_AW-1:0]   r_wbase;
  logic              r_bias_vld;
  logic              r_prod_vld;

  logic [IN_AW:0]       w_in_dim;
  logic [OUT_AW:0]      w_out_dim;
  logic                 w_last_k;
  logic                 w_last_n;
  logic signed [OUT_W-1:0] w_res;

  assign w_in_dim  = (in_dim_i  > IN_MAX)  ? IN_MAX  : in_dim_i;
  assign w_out_dim = (out_dim_i > OUT_MAX) ? OUT_MAX : out_dim_i;
  assign w_last_k  = ({1'b0, r_k} == r_in_dim  - (IN_AW+1)'(1));
  assign w_last_n  = ({1'b0, r_n} == r_out_dim - (OUT_AW+1)'(1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_in_dim   <= '0;
      r_out_dim  <= '0;
      r_k        <= '0;
      r_n        <= '0;
      r_wbase    <= '0;
      r_bias_vld <= 1'b0;
      r_prod_vld <= 1'b0;
    end else begin
      // Read data arrives one cycle after issue; these strobes line it up with the accumulator.
      r_bias_vld <= (r_state == LOAD_BIAS);
      r_prod_vld <= (r_state == MAC);
      case (r_state)
        IDLE: if (start_i) begin
          r_in_dim  <= w_in_dim;
          r_out_dim <= w_out_dim;
          r_n       <= '0;
          r_k       <= '0;
          r_wbase   <= '0;
          r_state   <= (w_out_dim == '0) ? FIN : LOAD_BIAS;
        end
        LOAD_BIAS: begin
          r_k     <= '0;
          r_state <= (r_in_dim == '0) ? DRAIN : MAC;
        end
        MAC: begin
          if (w_last_k) r_state <= DRAIN;
          else          r_k     <= r_k + 1'b1;
        end
        DRAIN: r_state <= OUT;
        OUT: if (out_ready_i) begin
          r_n     <= r_n + 1'b1;
          r_wbase <= r_wbase + W_AW'(r_in_dim);
          r_state <= w_last_n ? FIN : LOAD_BIAS;
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  fc_mac_acc #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT)
  ) u_mac_acc (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .bias_vld_i (r_bias_vld),
    .prod_vld_i (r_prod_vld),
    .b_rdata_i  (b_rdata_i),
    .x_rdata_i  (x_rdata_i),
    .w_rdata_i  (w_rdata_i),
    .res_o      (w_res)
  );

  assign busy_o      = (r_state != IDLE) && (r_state != FIN);
  assign done_o      = (r_state == FIN);
  assign mem_en_o    = (r_state == LOAD_BIAS) || (r_state == MAC);
  assign x_addr_o    = r_k;
  assign w_addr_o    = r_wbase + W_AW'(r_k);
  assign b_addr_o    = r_n;
  assign out_en_o    = (r_state == OUT);
  assign out_wdata_o = out_en_o ? 32'(w_res) : 32'd0;

endmodule
